// File: rtl/commit_write_scheduler_pkg.sv
// Shared commit/writeback types and constants.
// Imported by the write scheduler and its lookup CAM.
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package commit_write_scheduler_pkg;

  typedef logic        bool;
  typedef logic [4:0]  REG_ADDR;
  typedef logic [31:0] REG;

  typedef struct packed {
    bool     write_reg_need;
    REG_ADDR write_reg_addr;
    REG      result;
  } CMT_REQUIRE;

  typedef struct packed {
    REG_ADDR addr;
    REG      data;
  } WB_ENTRY;

  localparam REG_ADDR ZERO_REG_ADDR = 5'b0;

  function automatic bool slot_eligible(
    input CMT_REQUIRE r
  );
    return r.write_reg_need &&
           (r.write_reg_addr != ZERO_REG_ADDR);
  endfunction

endpackage

// File: rtl/commit_write_scheduler_wb_lookup_cam.sv
// Forwarding CAM over the pending-write queue.
// Walks entries oldest to youngest so the youngest match wins.
module wb_lookup_cam
  import commit_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  WB_ENTRY          q [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [AW-1:0]    head,
  input  logic [AW:0]      count,
  input  REG_ADDR          lookup_addr,
  output logic             hit,
  output REG               data
);

  logic [AW-1:0] idx;

  // age-ordered scan; a later (younger) match overrides
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (((AW+1)'(i) < count) && valid[idx] &&
          (q[idx].addr == lookup_addr)) begin
        hit  = 1'b1;
        data = q[idx].data;
      end
    end
  end

endmodule

// File: rtl/commit_write_scheduler.sv
// Funnels dual-issue commit writes onto one regfile port.
// Option: COMMIT_WAW_COALESCE_EN drops slot 0 on same-addr pairs.
module commit_write_scheduler
  import commit_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  CMT_REQUIRE               cmt_require [1:0],
  output bool                      regfile_write_ena,
  output REG_ADDR                  regfile_write_addr,
  output REG                       regfile_write_data,
  input  REG_ADDR                  lookup_addr,
  output bool                      lookup_hit,
  output REG                       lookup_data,
  output logic [$clog2(DEPTH):0]   pending_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  WB_ENTRY       mem_q [DEPTH];
  WB_ENTRY       mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  bool           ena_q, ena_d;
  REG_ADDR       addr_q, addr_d;
  REG            data_q, data_d;

  logic          elig0, elig1;
  logic          acc, pop;
  logic [CW-1:0] enq_n;
  logic [AW-1:0] idx1;
  logic [DEPTH-1:0] valid;
  logic          cam_hit;
  REG            cam_data;

  assign in_ready      = (count_q <= CW'(DEPTH - 2));
  assign acc           = in_valid && in_ready;
  assign pop           = (count_q != '0);
  assign pending_count = count_q;

  // slot eligibility, with optional same-address coalescing
  always_comb begin
    elig0 = slot_eligible(cmt_require[0]);
    elig1 = slot_eligible(cmt_require[1]);
`ifdef COMMIT_WAW_COALESCE_EN
    if (elig0 && elig1 &&
        (cmt_require[0].write_reg_addr ==
         cmt_require[1].write_reg_addr))
      elig0 = 1'b0;
`endif
  end

  // enqueue, pop and pointer/count update
  always_comb begin
    mem_d   = mem_q;
    enq_n   = '0;
    idx1    = tail_q + AW'(elig0);
    if (acc) begin
      if (elig0)
        mem_d[tail_q] = '{
          addr: cmt_require[0].write_reg_addr,
          data: cmt_require[0].result};
      if (elig1)
        mem_d[idx1] = '{
          addr: cmt_require[1].write_reg_addr,
          data: cmt_require[1].result};
      enq_n = CW'(elig0) + CW'(elig1);
    end
    tail_d  = tail_q + AW'(enq_n);
    head_d  = head_q + AW'(pop);
    count_d = count_q + enq_n - CW'(pop);
    ena_d   = pop;
    addr_d  = pop ? mem_q[head_q].addr : ZERO_REG_ADDR;
    data_d  = pop ? mem_q[head_q].data : '0;
  end

  // queue storage, pointers and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign regfile_write_ena  = ena_q;
  assign regfile_write_addr = addr_q;
  assign regfile_write_data = data_q;

  // occupancy mask derived from head and count
  always_comb begin
    valid = '0;
    for (int j = 0; j < DEPTH; j++)
      valid[j] = (CW'(AW'(j) - head_q) < count_q);
  end

  wb_lookup_cam #(
    .DEPTH (DEPTH)
  ) u_cam (
    .q           (mem_q),
    .valid       (valid),
    .head        (head_q),
    .count       (count_q),
    .lookup_addr (lookup_addr),
    .hit         (cam_hit),
    .data        (cam_data)
  );

  // queue beats the in-flight output register
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (lookup_addr != ZERO_REG_ADDR) begin
      if (cam_hit) begin
        lookup_hit  = 1'b1;
        lookup_data = cam_data;
      end else if (ena_q && (addr_q == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q;
      end
    end
  end

endmodule
